dma_tdd_sync_gen: RTL and testbench

Multi-channel TDD sync pulse generator. Detects a configurable edge on one external sync input, then drives NUM_CH independent output pulses. Each channel has its own run-time delay and pulse width. Sits between the external TDD sync pin and DMA/TDD consumers (DMA start, RF switch enables), and replaces fixed-width single-output sync pulsing.

---
 rtl/dma_tdd_sync_gen_if.sv | 28 ++
 rtl/dma_tdd_sync_gen.sv | 142 ++++++++++++++
 tb/tb_dma_tdd_sync_gen.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_tdd_sync_gen_if.sv
// Port bundle for dma_tdd_sync_gen: sync input, per-channel config and pulse/status outputs.
interface dma_tdd_sync_gen_if #(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned TRIG_CNT_WIDTH = 16
);
   logic                          sync_in;
   logic [1:0]                    edge_sel;
   logic [NUM_CH-1:0]             ch_enable;
   logic [NUM_CH-1:0]             retrig_en;
   logic [NUM_CH*CNT_WIDTH-1:0]   cfg_delay;
   logic [NUM_CH*CNT_WIDTH-1:0]   cfg_width;
   logic                          overrun_clr;
   logic [NUM_CH-1:0]             sync_out;
   logic [NUM_CH-1:0]             busy;
   logic [NUM_CH-1:0]             overrun;
   logic [TRIG_CNT_WIDTH-1:0]     trig_count;

   modport master (
      output sync_in, edge_sel, ch_enable, retrig_en, cfg_delay, cfg_width, overrun_clr,
      input  sync_out, busy, overrun, trig_count
   );

   modport slave (
      input  sync_in, edge_sel, ch_enable, retrig_en, cfg_delay, cfg_width, overrun_clr,
      output sync_out, busy, overrun, trig_count
   );
endinterface

// File: rtl/dma_tdd_sync_gen.sv
// Multi-channel TDD sync pulse generator: one synchronized edge detector fans out to
// NUM_CH independent delay/width pulse channels with retrigger and overrun tracking.
module dma_tdd_sync_gen #(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned TRIG_CNT_WIDTH = 16
) (
   input logic               clk,
   input logic               rstn,
   dma_tdd_sync_gen_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   logic                      r_s1, r_s2, r_s3;
   logic                      w_trig;
   logic [TRIG_CNT_WIDTH-1:0] r_trig_cnt;

   // Three-flop path: two for metastability, the third for edge detection.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= bus.sync_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_comb begin
      w_trig = 1'b0;
      case (bus.edge_sel)
         2'b00:   w_trig = r_s2 & ~r_s3;
         2'b01:   w_trig = ~r_s2 & r_s3;
         2'b10:   w_trig = r_s2 ^ r_s3;
         default: w_trig = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_trig_cnt <= '0;
      end else if (w_trig) begin
         r_trig_cnt <= r_trig_cnt + TRIG_CNT_WIDTH'(1);
      end
   end

   assign bus.trig_count = r_trig_cnt;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t               r_state;
      logic [CNT_WIDTH-1:0] r_cnt;
      logic [CNT_WIDTH-1:0] r_wid;
      logic                 r_out, r_busy, r_ovr;
      logic [CNT_WIDTH-1:0] w_dly, w_wid;
      logic                 w_hit, w_accept, w_ignore;

      assign w_dly    = bus.cfg_delay[gi*CNT_WIDTH +: CNT_WIDTH];
      assign w_wid    = bus.cfg_width[gi*CNT_WIDTH +: CNT_WIDTH];
      assign w_hit    = w_trig & bus.ch_enable[gi];
      assign w_accept = w_hit & ((r_state == ST_IDLE) | bus.retrig_en[gi]);
      assign w_ignore = w_hit & (r_state != ST_IDLE) & ~bus.retrig_en[gi];

      // Width is latched at acceptance; delay lives only in the counter.
      always_ff @(posedge clk) begin
         if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wid   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
         end else begin
            if (w_ignore) begin
               r_ovr <= 1'b1;
            end else if (bus.overrun_clr) begin
               r_ovr <= 1'b0;
            end

            if (!bus.ch_enable[gi]) begin
               r_state <= ST_IDLE;
               r_out   <= 1'b0;
               r_busy  <= 1'b0;
            end else if (w_accept) begin
               r_wid <= w_wid;
               if (w_wid == '0) begin
                  r_state <= ST_IDLE;
                  r_out   <= 1'b0;
                  r_busy  <= 1'b0;
               end else if (w_dly == '0) begin
                  r_state <= ST_ACTIVE;
                  r_cnt   <= w_wid - CNT_WIDTH'(1);
                  r_out   <= 1'b1;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_DELAY;
                  r_cnt   <= w_dly - CNT_WIDTH'(1);
                  r_out   <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end else begin
               case (r_state)
                  ST_DELAY: begin
                     if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                     end else begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= r_wid - CNT_WIDTH'(1);
                        r_out   <= 1'b1;
                     end
                  end
                  ST_ACTIVE: begin
                     if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                     end else begin
                        r_state <= ST_IDLE;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b0;
                     end
                  end
                  default: begin
                     r_state <= ST_IDLE;
                     r_out   <= 1'b0;
                     r_busy  <= 1'b0;
                  end
               endcase
            end
         end
      end

      assign bus.sync_out[gi] = r_out;
      assign bus.busy[gi]     = r_busy;
      assign bus.overrun[gi]  = r_ovr;
   end

endmodule

// File: tb/tb_dma_tdd_sync_gen.sv
// Scoreboard bench for dma_tdd_sync_gen: per-cycle expected {busy,sync_out} queued at
// stimulus time and compared every cycle after the active edge.
module tb_dma_tdd_sync_gen;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CW     = 32;
   localparam int unsigned TW     = 8;
   localparam int          MAXN   = 128;

   typedef struct {
      string                 tag;
      logic [2*NUM_CH-1:0]   v;
   } sb_t;

   logic clk;
   logic rstn;

   dma_tdd_sync_gen_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW), .TRIG_CNT_WIDTH(TW)) bus ();

   dma_tdd_sync_gen #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW), .TRIG_CNT_WIDTH(TW)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int              n_chk  = 0;
   int              n_pass = 0;
   sb_t             sb_q[$];
   sb_t             sb_e;
   logic [NUM_CH-1:0] e_so [MAXN];
   logic [NUM_CH-1:0] e_bz [MAXN];
   logic [TW-1:0]   exp_trig;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Compare one queued sample per cycle, just after the active edge.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         sb_e = sb_q.pop_front();
         check_eq(sb_e.tag, 64'({bus.busy, bus.sync_out}), 64'(sb_e.v));
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_win();
      for (int j = 0; j < MAXN; j++) begin
         e_so[j] = '0;
         e_bz[j] = '0;
      end
   endtask

   // Channel ch busy over [bs,last], pulsing over [as,last]; index j = sample after edge k+j.
   task automatic add_win(input int ch, input int bs, input int as, input int last);
      for (int j = bs; j <= last; j++) e_bz[j][ch] = 1'b1;
      for (int j = as; j <= last; j++) e_so[j][ch] = 1'b1;
   endtask

   task automatic commit(input string tag, input int n);
      sb_t s;
      for (int j = 0; j < n; j++) begin
         s.tag = $sformatf("%s[%0d]", tag, j);
         s.v   = {e_bz[j], e_so[j]};
         sb_q.push_back(s);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() > 0) begin
         check_eq("drain_timeout", 64'(sb_q.size()), 64'd0);
         sb_q.delete();
      end
      wait_n(4);
   endtask

   task automatic set_cfg(input int ch, input int d, input int w);
      bus.cfg_delay[ch*CW +: CW] = CW'(d);
      bus.cfg_width[ch*CW +: CW] = CW'(w);
   endtask

   initial begin
      rstn            = 1'b0;
      bus.sync_in     = 1'b0;
      bus.edge_sel    = 2'b00;
      bus.ch_enable   = '0;
      bus.retrig_en   = '0;
      bus.cfg_delay   = '0;
      bus.cfg_width   = '0;
      bus.overrun_clr = 1'b0;
      exp_trig        = '0;
      wait_n(3);
      check_eq("rst_sync_out", 64'(bus.sync_out), 64'd0);
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_overrun", 64'(bus.overrun), 64'd0);
      check_eq("rst_trig", 64'(bus.trig_count), 64'd0);
      rstn = 1'b1;
      wait_n(4);

      // Single channel, D=0 W=5
      set_cfg(0, 0, 5);
      bus.ch_enable = 4'b0001;
      clear_win(); add_win(0, 2, 2, 6); commit("t1", 9);
      bus.sync_in = 1'b1;
      wait_n(4); bus.sync_in = 1'b0;
      drain();
      exp_trig = exp_trig + TW'(1);
      check_eq("t1_trig", 64'(bus.trig_count), 64'(exp_trig));

      // Four channels, mixed delays, zero width on ch3
      set_cfg(0, 0, 2); set_cfg(1, 3, 4); set_cfg(2, 10, 1); set_cfg(3, 0, 0);
      bus.ch_enable = 4'b1111;
      clear_win();
      add_win(0, 2, 2, 3); add_win(1, 2, 5, 8); add_win(2, 2, 12, 12);
      commit("t2", 15);
      bus.sync_in = 1'b1;
      wait_n(4); bus.sync_in = 1'b0;
      drain();
      exp_trig = exp_trig + TW'(1);
      check_eq("t2_trig", 64'(bus.trig_count), 64'(exp_trig));

      // Second trigger during pulse, retrigger disabled -> overrun
      set_cfg(1, 0, 20);
      bus.ch_enable = 4'b0010;
      bus.retrig_en = 4'b0000;
      clear_win(); add_win(1, 2, 2, 21); commit("t3a", 24);
      bus.sync_in = 1'b1;
      wait_n(4); bus.sync_in = 1'b0;
      wait_n(4); bus.sync_in = 1'b1;
      drain();
      bus.sync_in = 1'b0;
      exp_trig = exp_trig + TW'(2);
      check_eq("t3a_trig", 64'(bus.trig_count), 64'(exp_trig));
      check_eq("t3a_overrun", 64'(bus.overrun), 64'b0010);
      bus.overrun_clr = 1'b1;
      wait_n(1); bus.overrun_clr = 1'b0;
      wait_n(1);
      check_eq("t3a_overrun_clr", 64'(bus.overrun), 64'd0);
      wait_n(4);

      // Same with retrigger allowed -> 28 continuous cycles
      bus.retrig_en = 4'b0010;
      clear_win(); add_win(1, 2, 2, 29); commit("t3b", 32);
      bus.sync_in = 1'b1;
      wait_n(4); bus.sync_in = 1'b0;
      wait_n(4); bus.sync_in = 1'b1;
      drain();
      bus.sync_in = 1'b0;
      exp_trig = exp_trig + TW'(2);
      check_eq("t3b_trig", 64'(bus.trig_count), 64'(exp_trig));
      check_eq("t3b_overrun", 64'(bus.overrun), 64'd0);
      bus.retrig_en = '0;
      wait_n(4);

      // Both edges
      bus.edge_sel = 2'b10;
      set_cfg(0, 0, 2);
      bus.ch_enable = 4'b0001;
      clear_win(); add_win(0, 2, 2, 3); add_win(0, 8, 8, 9); commit("t4b", 12);
      bus.sync_in = 1'b1;
      wait_n(6); bus.sync_in = 1'b0;
      drain();
      exp_trig = exp_trig + TW'(2);
      check_eq("t4b_trig", 64'(bus.trig_count), 64'(exp_trig));

      // Edges disabled
      bus.edge_sel = 2'b11;
      clear_win(); commit("t4n", 12);
      bus.sync_in = 1'b1;
      wait_n(6); bus.sync_in = 1'b0;
      drain();
      check_eq("t4n_trig", 64'(bus.trig_count), 64'(exp_trig));

      // Width change mid-pulse has no effect
      bus.edge_sel = 2'b00;
      set_cfg(0, 0, 100);
      clear_win(); add_win(0, 2, 2, 101); commit("t5a", 104);
      bus.sync_in = 1'b1;
      wait_n(4); bus.sync_in = 1'b0;
      wait_n(16); set_cfg(0, 0, 3);
      drain();
      exp_trig = exp_trig + TW'(1);

      // Enable dropped at pulse cycle 10
      set_cfg(0, 0, 100);
      clear_win(); add_win(0, 2, 2, 11); commit("t5b", 14);
      bus.sync_in = 1'b1;
      wait_n(4); bus.sync_in = 1'b0;
      wait_n(8); bus.ch_enable = 4'b0000;
      drain();
      bus.ch_enable = 4'b0001;
      exp_trig = exp_trig + TW'(1);
      check_eq("t5_trig", 64'(bus.trig_count), 64'(exp_trig));

      // Reset during ACTIVE
      set_cfg(0, 0, 10);
      clear_win(); add_win(0, 2, 2, 4); commit("t6", 10);
      bus.sync_in = 1'b1;
      wait_n(3); bus.sync_in = 1'b0;
      wait_n(2); rstn = 1'b0;
      wait_n(1); rstn = 1'b1;
      drain();
      exp_trig = '0;
      check_eq("t6_trig", 64'(bus.trig_count), 64'(exp_trig));
      check_eq("t6_overrun", 64'(bus.overrun), 64'd0);

      // Trigger counter wrap
      bus.ch_enable = '0;
      bus.edge_sel  = 2'b10;
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         bus.sync_in = ~bus.sync_in;
      end
      wait_n(4);
      check_eq("wrap_allones", 64'(bus.trig_count), 64'hFF);
      bus.sync_in = ~bus.sync_in;
      wait_n(4);
      check_eq("wrap_zero", 64'(bus.trig_count), 64'd0);
      check_eq("wrap_sync_out", 64'(bus.sync_out), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
